// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for the decode stage: extracts and extends the
// immediate, forms pc+imm, flags illegal opcodes and counts them behind a valid/ready skid-free register.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_sel,
  output logic             out_has_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_I     = 3'd1;
  localparam logic [2:0] SEL_S     = 3'd2;
  localparam logic [2:0] SEL_B     = 3'd3;
  localparam logic [2:0] SEL_U     = 3'd4;
  localparam logic [2:0] SEL_J     = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;
  localparam logic [2:0] SEL_Z     = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [11:0] imm_i_s;
  logic signed [11:0] imm_s_s;
  logic signed [12:0] imm_b_s;
  logic signed [31:0] imm_u_s;
  logic signed [20:0] imm_j_s;
  logic [XLEN-1:0]    shamt_d;
  logic [XLEN-1:0]    zimm_d;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign imm_i_s = in_instr[31:20];
  assign imm_s_s = {in_instr[31:25], in_instr[11:7]};
  assign imm_b_s = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u_s = {in_instr[31:12], 12'b0};
  assign imm_j_s = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign zimm_d  = XLEN'(in_instr[19:15]);

  // RV64 shifts carry a 6-bit shift amount, RV32 only 5.
  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt_d = XLEN'(in_instr[25:20]);
    end else begin : g_shamt32
      assign shamt_d = XLEN'(in_instr[24:20]);
    end
  endgenerate

  logic [XLEN-1:0] imm_d;
  logic [2:0]      sel_d;
  logic            illegal_d;
  logic [XLEN-1:0] target_d;

  always_comb begin
    imm_d     = '0;
    sel_d     = SEL_NONE;
    illegal_d = 1'b0;
    case (opcode)
      7'h03, 7'h67: begin
        sel_d = SEL_I;
        imm_d = XLEN'(imm_i_s);
      end
      7'h13, 7'h1B: begin
        if (opcode == 7'h1B && XLEN != 64) begin
          illegal_d = 1'b1;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          sel_d = SEL_SHAMT;
          imm_d = shamt_d;
        end else begin
          sel_d = SEL_I;
          imm_d = XLEN'(imm_i_s);
        end
      end
      7'h23: begin
        sel_d = SEL_S;
        imm_d = XLEN'(imm_s_s);
      end
      7'h63: begin
        sel_d = SEL_B;
        imm_d = XLEN'(imm_b_s);
      end
      7'h37, 7'h17: begin
        sel_d = SEL_U;
        imm_d = XLEN'(imm_u_s);
      end
      7'h6F: begin
        sel_d = SEL_J;
        imm_d = XLEN'(imm_j_s);
      end
      7'h73: begin
        if (EN_ZIMM) begin
          sel_d = SEL_Z;
          imm_d = zimm_d;
        end
      end
      7'h33, 7'h0F: ;
      7'h3B: illegal_d = (XLEN != 64);
      default: illegal_d = 1'b1;
    endcase
  end

  assign target_d = in_pc + imm_d;

  logic            valid_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      sel_q;
  logic            has_imm_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] pc_q;
  logic            illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic            accept;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      sel_q     <= SEL_NONE;
      has_imm_q <= 1'b0;
      target_q  <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      // Data registers only move on an accept, so they hold under backpressure and when empty.
      if (accept) begin
        imm_q     <= imm_d;
        sel_q     <= sel_d;
        has_imm_q <= (sel_d != SEL_NONE);
        target_q  <= target_d;
        pc_q      <= in_pc;
        illegal_q <= illegal_d;
        if (illegal_d && cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_imm     = imm_q;
  assign out_sel     = sel_q;
  assign out_has_imm = has_imm_q;
  assign out_target  = target_q;
  assign out_pc      = pc_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 instance (CNT_W=2, zimm on) and an RV64 instance (zimm off)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        r32, v32, h32, il32;
  logic [31:0] imm32, tgt32, pc32;
  logic [2:0]  sel32;
  logic [1:0]  cnt32;

  logic        r64, v64, h64, il64;
  logic [63:0] imm64, tgt64, pc64;
  logic [2:0]  sel64;
  logic [15:0] cnt64;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2), .EN_ZIMM(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_sel(sel32), .out_has_imm(h32), .out_target(tgt32),
    .out_pc(pc32), .out_illegal(il32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16), .EN_ZIMM(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_sel(sel64), .out_has_imm(h64), .out_target(tgt64),
    .out_pc(pc64), .out_illegal(il64), .illegal_cnt(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected state of both instances.
  bit          m_valid;
  logic [63:0] m_imm32, m_imm64, m_tgt32, m_tgt64, m_pc32, m_pc64;
  logic [2:0]  m_sel32, m_sel64;
  bit          m_ill32, m_ill64;
  int          m_cnt32, m_cnt64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value computed as a signed integer from the weighted instruction fields.
  function automatic void ref_dec(input logic [31:0] ins, input int xl, input bit ez,
                                  output logic [63:0] imm, output logic [2:0] sel, output bit ill);
    longint v = 0;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    sel = 3'd0;
    ill = 1'b0;
    case (op)
      7'h03, 7'h67: begin
        sel = 3'd1;
        v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
      end
      7'h13, 7'h1B: begin
        if (op == 7'h1B && xl == 32) ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          sel = 3'd6;
          v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          sel = 3'd1;
          v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
        end
      end
      7'h23: begin
        sel = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
      end
      7'h63: begin
        sel = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
            - (ins[31] ? 4096 : 0);
      end
      7'h37, 7'h17: begin
        sel = 3'd4;
        v = longint'(ins[31:12]) * 4096 - (ins[31] ? (longint'(1) << 32) : longint'(0));
      end
      7'h6F: begin
        sel = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
            - (ins[31] ? (longint'(1) << 20) : longint'(0));
      end
      7'h73: if (ez) begin sel = 3'd7; v = longint'(ins[19:15]); end
      7'h33, 7'h0F: ;
      7'h3B: ill = (xl == 32);
      default: ill = 1'b1;
    endcase
    imm = v;
    if (xl == 32) imm[63:32] = 32'h0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid32"}, 64'(v32), 64'(m_valid));
    chk({tag, ".valid64"}, 64'(v64), 64'(m_valid));
    chk({tag, ".imm32"}, 64'(imm32), m_imm32);
    chk({tag, ".imm64"}, imm64, m_imm64);
    chk({tag, ".sel32"}, 64'(sel32), 64'(m_sel32));
    chk({tag, ".sel64"}, 64'(sel64), 64'(m_sel64));
    chk({tag, ".has32"}, 64'(h32), 64'(m_sel32 != 3'd0));
    chk({tag, ".has64"}, 64'(h64), 64'(m_sel64 != 3'd0));
    chk({tag, ".tgt32"}, 64'(tgt32), m_tgt32);
    chk({tag, ".tgt64"}, tgt64, m_tgt64);
    chk({tag, ".pc32"}, 64'(pc32), m_pc32);
    chk({tag, ".pc64"}, pc64, m_pc64);
    chk({tag, ".ill32"}, 64'(il32), 64'(m_ill32));
    chk({tag, ".ill64"}, 64'(il64), 64'(m_ill64));
    chk({tag, ".cnt32"}, 64'(cnt32), 64'(m_cnt32));
    chk({tag, ".cnt64"}, 64'(cnt64), 64'(m_cnt64));
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_imm32 = '0; m_imm64 = '0; m_tgt32 = '0; m_tgt64 = '0; m_pc32 = '0; m_pc64 = '0;
    m_sel32 = '0; m_sel64 = '0; m_ill32 = 0; m_ill64 = 0; m_cnt32 = 0; m_cnt64 = 0;
  endtask

  // One clock cycle: drive, check in_ready, clock, advance the model, check every output.
  task automatic cyc(input string tag, input bit v, input logic [31:0] ins, input logic [63:0] pc,
                     input bit rdy, input bit fl);
    bit exp_rdy, acc;
    logic [63:0] i32, i64;
    logic [2:0]  s32, s64;
    bit          l32, l64;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (!m_valid || rdy);
    chk({tag, ".ready32"}, 64'(r32), 64'(exp_rdy));
    chk({tag, ".ready64"}, 64'(r64), 64'(exp_rdy));
    acc = v && exp_rdy;
    ref_dec(ins, 32, 1'b1, i32, s32, l32);
    ref_dec(ins, 64, 1'b0, i64, s64, l64);
    @(posedge clk);
    #1;
    if (fl) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (rdy) m_valid = 0;
    if (acc) begin
      m_imm32 = i32; m_sel32 = s32; m_ill32 = l32;
      m_imm64 = i64; m_sel64 = s64; m_ill64 = l64;
      m_pc32 = {32'h0, pc[31:0]}; m_pc64 = pc;
      m_tgt32 = (pc + i32) & 64'hFFFF_FFFF;
      m_tgt64 = pc + i64;
      if (l32 && m_cnt32 < 3) m_cnt32++;
      if (l64 && m_cnt64 < 65535) m_cnt64++;
    end
    $display("[%0t] %s v=%0b ins=%h rdy=%0b fl=%0b acc=%0b -> out_valid=%0b imm32=%h imm64=%h",
             $time, tag, v, ins, rdy, fl, acc, v32, imm32, imm64);
    check_outputs(tag);
  endtask

  logic [6:0] ops [16] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                          7'h6F, 7'h73, 7'h33, 7'h0F, 7'h3B, 7'h7F, 7'h00, 7'h5B};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    model_reset();
    #2;
    check_outputs("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc("itype", 1, 32'hFFF00093, 64'h100, 1, 0);
    chk("itype.imm_const", 64'(imm32), 64'hFFFF_FFFF);
    chk("itype.tgt_const", 64'(tgt32), 64'h0000_00FF);
    cyc("btype", 1, 32'hFE000EE3, 64'h100, 1, 0);
    chk("btype.imm_const", 64'(imm32), 64'hFFFF_FFFC);
    chk("btype.tgt_const", 64'(tgt32), 64'h0000_00FC);
    cyc("lui", 1, 32'h800000B7, 64'h2000, 1, 0);
    chk("lui.imm64_const", imm64, 64'hFFFF_FFFF_8000_0000);
    cyc("slli", 1, 32'h03F09093, 64'h2004, 1, 0);
    chk("slli.imm64_const", imm64, 64'd63);
    chk("slli.sel64_const", 64'(sel64), 64'd6);
    cyc("csrrwi", 1, 32'h3401D073, 64'h2008, 1, 0);
    cyc("drain", 0, 32'h0, 64'h0, 1, 0);

    // Backpressure: A accepted, B waits three cycles, then follows A out.
    cyc("bp_a", 1, 32'h00A12423, 64'h300, 1, 0);
    for (int i = 0; i < 3; i++) cyc("bp_hold", 1, 32'hFFDFF06F, 64'h304, 0, 0);
    cyc("bp_b", 1, 32'hFFDFF06F, 64'h304, 1, 0);
    cyc("bp_out", 0, 32'h0, 64'h0, 1, 0);

    // Flush blocks the illegal op; then saturation of the 2-bit counter.
    cyc("flush", 1, 32'h0000007F, 64'h400, 1, 1);
    for (int i = 0; i < 5; i++) cyc("illegal", 1, 32'h0000007F, 64'h404, 1, 0);
    chk("illegal.cnt32_sat", 64'(cnt32), 64'd3);
    cyc("rtype", 1, 32'h00B50533, 64'h408, 1, 0);

    // Reset mid-transfer while a result is held.
    cyc("pre_rst", 1, 32'h12345037, 64'h500, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [63:0] p;
      r = $urandom();
      p = {$urandom(), $urandom()};
      cyc("rand", ($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 15)]}, p,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
